// File: rtl/mm3_mem_arbiter.sv
// mm3_mem_arbiter
//   Arbitrates access to the 32x32b layer-3 output memory between one
//   producer (matmul writer) and two consumers (argmax, display readback).
//   One write and one round-robin read can be granted per cycle. Each entry
//   has a written bit, and a read of an unwritten entry stalls until the
//   entry has been written. fill_cnt/full report how much of the output
//   vector has been produced since the last clear.
//
// Ports
//   clk, resetn            clock (posedge), asynchronous active-low reset
//   clear                  start a new layer: drop written bits, no grants
//   wr_req/addr/data       producer write request
//   wr_gnt                 write accepted this cycle (combinational)
//   wr_err                 one-cycle pulse after an out-of-range write
//   rdN_req/addr           consumer read requests (N = 0, 1)
//   rdN_gnt                read accepted this cycle (combinational)
//   rdN_rvalid/rdata       read return, two cycles after the grant
//   mem_write_addr/data_in/write_enable, mem_read_addr  registered memory drive
//   mem_data_out           memory read data, one cycle after mem_read_addr
//   fill_cnt, full         distinct entries written, all entries written
module mm3_mem_arbiter #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     clear,
    input  logic                     wr_req,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic signed [DATA_W-1:0] wr_data,
    output logic                     wr_gnt,
    output logic                     wr_err,
    input  logic                     rd0_req,
    input  logic [ADDR_W-1:0]        rd0_addr,
    input  logic                     rd1_req,
    input  logic [ADDR_W-1:0]        rd1_addr,
    output logic                     rd0_gnt,
    output logic                     rd1_gnt,
    output logic                     rd0_rvalid,
    output logic                     rd1_rvalid,
    output logic signed [DATA_W-1:0] rd0_rdata,
    output logic signed [DATA_W-1:0] rd1_rdata,
    output logic [ADDR_W-1:0]        mem_write_addr,
    output logic signed [DATA_W-1:0] mem_data_in,
    output logic                     mem_write_enable,
    output logic [ADDR_W-1:0]        mem_read_addr,
    input  logic signed [DATA_W-1:0] mem_data_out,
    output logic [5:0]               fill_cnt,
    output logic                     full
);

    localparam int                IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [5:0]        DEPTH_C = 6'(DEPTH);

    logic [DEPTH-1:0] written;
    logic             wr_in_range;
    logic             wr_new_entry;
    logic [5:0]       fill_next;
    logic             rd0_in_range, rd1_in_range;
    logic             rd0_elig, rd1_elig;
    logic             rr_prio;              // 0: rd0 wins a tie, 1: rd1 wins
    logic             s1_vld, s1_sel, s1_oor;
    logic             s2_vld, s2_sel, s2_oor;

    // ---------------- write path ----------------
    assign wr_gnt       = wr_req & ~clear;
    assign wr_in_range  = wr_addr < DEPTH_A;
    assign wr_new_entry = wr_gnt & wr_in_range & ~written[wr_addr[IDX_W-1:0]];
    assign fill_next    = wr_new_entry ? fill_cnt + 6'd1 : fill_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_write_enable <= 1'b0;
            mem_write_addr   <= '0;
            mem_data_in      <= '0;
            wr_err           <= 1'b0;
        end else begin
            mem_write_enable <= 1'b0;
            wr_err           <= 1'b0;
            if (wr_gnt) begin
                if (wr_in_range) begin
                    mem_write_enable <= 1'b1;
                    mem_write_addr   <= wr_addr;
                    mem_data_in      <= wr_data;
                end else begin
                    wr_err <= 1'b1;
                end
            end
        end
    end

    // full tracks fill_next so it rises together with fill_cnt reaching DEPTH.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            written  <= '0;
            fill_cnt <= '0;
            full     <= 1'b0;
        end else if (clear) begin
            written  <= '0;
            fill_cnt <= '0;
            full     <= 1'b0;
        end else begin
            if (wr_new_entry) begin
                written[wr_addr[IDX_W-1:0]] <= 1'b1;
            end
            fill_cnt <= fill_next;
            full     <= (fill_next == DEPTH_C);
        end
    end

    // ---------------- read arbitration ----------------
    // A read must not overlap a write to the same entry that is either being
    // granted now or still sitting in the memory write registers; otherwise
    // the read would race the write at the memory and return stale data.
    assign rd0_in_range = rd0_addr < DEPTH_A;
    assign rd1_in_range = rd1_addr < DEPTH_A;

    assign rd0_elig = rd0_req & ~clear
                    & (~rd0_in_range | written[rd0_addr[IDX_W-1:0]])
                    & ~(mem_write_enable & (mem_write_addr == rd0_addr))
                    & ~(wr_gnt & (wr_addr == rd0_addr));
    assign rd1_elig = rd1_req & ~clear
                    & (~rd1_in_range | written[rd1_addr[IDX_W-1:0]])
                    & ~(mem_write_enable & (mem_write_addr == rd1_addr))
                    & ~(wr_gnt & (wr_addr == rd1_addr));

    assign rd0_gnt = rd0_elig & (~rd1_elig | ~rr_prio);
    assign rd1_gnt = rd1_elig & (~rd0_elig |  rr_prio);

    // ---------------- read pipeline ----------------
    // Stage 1 covers the memory access cycle, stage 2 the return cycle.
    // clear does not touch these so reads already granted still complete.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_prio       <= 1'b0;
            mem_read_addr <= '0;
            s1_vld        <= 1'b0;
            s1_sel        <= 1'b0;
            s1_oor        <= 1'b0;
            s2_vld        <= 1'b0;
            s2_sel        <= 1'b0;
            s2_oor        <= 1'b0;
        end else begin
            if (rd0_gnt | rd1_gnt) begin
                rr_prio       <= rd0_gnt;
                mem_read_addr <= rd1_gnt ? rd1_addr : rd0_addr;
            end
            s1_vld <= rd0_gnt | rd1_gnt;
            s1_sel <= rd1_gnt;
            s1_oor <= rd1_gnt ? ~rd1_in_range : ~rd0_in_range;
            s2_vld <= s1_vld;
            s2_sel <= s1_sel;
            s2_oor <= s1_oor;
        end
    end

    assign rd0_rvalid = s2_vld & ~s2_sel;
    assign rd1_rvalid = s2_vld &  s2_sel;
    assign rd0_rdata  = (rd0_rvalid & ~s2_oor) ? mem_data_out : '0;
    assign rd1_rdata  = (rd1_rvalid & ~s2_oor) ? mem_data_out : '0;

endmodule
